input_conditioner: RTL and testbench
====================================

# input_conditioner

Synchronises and debounces the board switch/button inputs (`sw_i`, `reg_sel`) before they reach `sccomp`. The block sits between the FPGA pins and the top-level control logic. It produces three outputs per bit: a clean, glitch-free level, a one-cycle rise pulse and a one-cycle fall pulse. Display-mode selection, pause switches and address stepping therefore see stable values, never raw bouncing or metastable signals.

## Interface
Parameters:
- `WIDTH`, 16: number of independent input bits.
- `SYNC_STAGES`, 2: flip-flops in each synchroniser chain; must be at least 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a new value must persist before it is accepted (10 ms at 100 MHz); must be at least 1.
- `RESET_VAL`, {WIDTH{1'b0}}: value loaded into the synchroniser flops and `level_o` during reset.

Ports:
- `clk`, in, 1: the single clock; every register is clocked on its rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `raw_i`, in, WIDTH: raw pin inputs, asynchronous to `clk`.
- `level_o`, out, WIDTH: debounced level of each bit, registered.
- `rise_o`, out, WIDTH: one-cycle pulse in the cycle that `level_o[i]` goes 0→1, registered.
- `fall_o`, out, WIDTH: one-cycle pulse in the cycle that `level_o[i]` goes 1→0, registered.
- `changed_o`, out, 1: registered OR of all `rise_o` and `fall_o` bits; asserted in the same cycle as those pulses.

## Operation
- **Synchroniser.** Each bit passes through a `SYNC_STAGES`-deep flop chain. `sync_q[i]` is the output of the last stage.
- **Per-bit state machine,** with a counter of width $clog2(DEBOUNCE_CYCLES):
  - STABLE (`sync_q == level`): counter is held at 0.
  - PENDING (`sync_q != level`): counter increments by 1 each cycle.
  - If the counter equals DEBOUNCE_CYCLES-1 while `sync_q != level`: `level <= sync_q`, counter returns to 0, and the matching `rise` or `fall` bit is set for exactly one cycle.
  - If `sync_q == level` at any cycle while PENDING, the counter clears to 0, `level` is unchanged and no pulse is produced. A glitch shorter than `DEBOUNCE_CYCLES` cycles is therefore fully rejected.
- **Pulse width.** Pulses last exactly one cycle. They clear on the following edge regardless of input.
- **Bit independence.** Bits are fully independent. Any number of bits may change or pulse in the same cycle.
- **Counter range.** The counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- **Reset, including reset in the middle of a count.** Asserting `rstn` low forces, immediately and asynchronously:
  - synchroniser flops = RESET_VAL
  - `level_o` = RESET_VAL
  - all counters = 0
  - `rise_o`, `fall_o`, `changed_o` = 0

  A pending count is discarded. After release, a raw value that differs from RESET_VAL needs the full latency again and then produces a pulse.

## Timing
- **Reference edge.** Edge k is the first rising edge after which `raw_i[i]` is stable at its new value.
- **Synchroniser output.** `sync_q[i]` takes the new value after edge k+SYNC_STAGES-1.
- **Level update.** `level_o[i]` updates after edge k+SYNC_STAGES-1+DEBOUNCE_CYCLES, i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges counting k itself.
- **Pulse timing.** `rise_o`/`fall_o`/`changed_o` are high for the single cycle that starts at that same edge.
- **Rejection limit.** A new value that persists for only DEBOUNCE_CYCLES-1 cycles after `sync_q` produces no output change.
- **Minimum latency.** With DEBOUNCE_CYCLES=1 the latency is SYNC_STAGES+1 edges: a pure synchroniser plus one registered change-detect stage.
- **Input handshake.** None; `raw_i` is free-running.
- **Output quality.** All outputs come straight from flops, so there is no combinational path from input to output.

## Structure
- **Shared constants** go in `macro.v`:
  - `SW_WIDTH` (16)
  - `DEBOUNCE_DEFAULT` (1_000_000)
  - `DEBOUNCE_SIM` (4), used by benches.
- **Sub-module.** A single-bit `debounce_bit` contains the synchroniser chain, counter, level register and edge registers, with the same parameters (width fixed at 1).
- **Top level.** `input_conditioner` instantiates WIDTH copies of `debounce_bit` in a generate loop and registers the OR-reduction that drives `changed_o`.

## Test plan
All scenarios use WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=0.
1. **Reset.** Hold `rstn`=0 with `raw_i`=4'hF → all outputs 0. Release reset → `level_o`=4'hF after 6 edges, with `rise_o`=4'hF and `changed_o`=1 for exactly one cycle.
2. **Clean step.** Drive `raw_i[0]` 0→1 before edge k → `level_o[0]`=1 after edge k+5. `rise_o[0]` is a single-cycle pulse and the other bits stay 0. Drive it back 1→0 → `fall_o[0]` pulses after the same latency.
3. **Glitch rejection.** Pulse `raw_i[1]` high for 3 cycles → `level_o[1]` stays 0 and no pulse appears. Then hold it high for 4 or more cycles → it is accepted.
4. **Bounce.** Apply the pattern 1,0,1,1,0,1,1,1,1 on `raw_i[2]` → exactly one `rise_o[2]` pulse, 4 cycles after the final run of 1s reaches `sync_q`.
5. **Simultaneous events.** Bit 0 rises while bit 3 falls, aligned to the same edge → `rise_o`=4'b0001 and `fall_o`=4'b1000 in the same cycle, `changed_o`=1 for one cycle.
6. **Reset mid-count.** Assert `rstn` low 2 cycles into a PENDING count on bit 1 → counter cleared and no pulse during reset. After release, the full 6-edge latency applies again.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the switch/button input conditioner.
//   SW_WIDTH          board switch count
//   DEBOUNCE_DEFAULT  10 ms at 100 MHz
//   DEBOUNCE_SIM      short debounce window used by benches
//   db_out_t          per-bit conditioned outputs (level + edge pulses)
package input_conditioner_pkg;

  localparam int SW_WIDTH         = 16;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  localparam int DEBOUNCE_SIM     = 4;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } db_out_t;

  // A one-cycle window still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// Single-bit synchroniser + debouncer + edge detector.
//   clk, rstn : clock, async active-low reset
//   raw       : asynchronous pin input
//   out       : registered debounced level and one-cycle rise/fall pulses
//   accept    : combinational "level changes at this edge" strobe, used by
//               the parent to register changed_o alongside the pulses
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic    clk,
  input  logic    rstn,
  input  logic    raw,
  output db_out_t out,
  output logic    accept
);

  localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CW-1:0]          cnt;
  logic                   level_q, rise_q, fall_q;
  logic                   pending;

  assign sync_q  = sync_r[SYNC_STAGES-1];
  assign pending = (sync_q != level_q);
  // Counter saturates at CNT_MAX by construction: reaching it while pending
  // always accepts and clears, so no wrap is possible.
  assign accept  = pending && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_r  <= {SYNC_STAGES{RESET_VAL}};
      cnt     <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      rise_q <= accept &&  sync_q;
      fall_q <= accept && !sync_q;
      if (accept) begin
        level_q <= sync_q;
        cnt     <= '0;
      end else if (pending) begin
        cnt <= cnt + 1'b1;
      end else begin
        // Input returned to the accepted level: drop the partial count.
        cnt <= '0;
      end
    end
  end

  assign out.level = level_q;
  assign out.rise  = rise_q;
  assign out.fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Conditions WIDTH asynchronous switch/button inputs for the control logic.
//   clk, rstn : clock, async active-low reset
//   raw_i     : raw pin inputs (asynchronous)
//   level_o   : debounced levels (registered)
//   rise_o    : one-cycle 0->1 pulses (registered)
//   fall_o    : one-cycle 1->0 pulses (registered)
//   changed_o : OR of all pulses, aligned with them (registered)
// SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int               WIDTH           = SW_WIDTH,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             changed_o
);

  db_out_t          bit_out [WIDTH];
  logic [WIDTH-1:0] accept;
  logic             changed_q;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (RESET_VAL[g])
    ) u_bit (
      .clk    (clk),
      .rstn   (rstn),
      .raw    (raw_i[g]),
      .out    (bit_out[g]),
      .accept (accept[g])
    );
    assign level_o[g] = bit_out[g].level;
    assign rise_o[g]  = bit_out[g].rise;
    assign fall_o[g]  = bit_out[g].fall;
  end

  // Registered from the per-bit accept strobes (not from the pulse flops) so
  // it lands in the same cycle as rise_o/fall_o rather than one later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) changed_q <= 1'b0;
    else       changed_q <= |accept;
  end

  assign changed_o = changed_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (WIDTH=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, RESET_VAL=0). The reference model treats the
// synchroniser as a fixed SYNC_STAGES-edge delay of the sampled input and
// accepts a new level once the last DEBOUNCE_CYCLES delayed samples all
// disagree with the current level.
module tb_input_conditioner;

  localparam int W = 4;
  localparam int S = 2;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] raw_i;
  logic [W-1:0] level_o, rise_o, fall_o;
  logic         changed_o;

  int tests = 0;
  int fails = 0;

  input_conditioner #(
    .WIDTH           (W),
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .RESET_VAL       ('0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .raw_i     (raw_i),
    .level_o   (level_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .changed_o (changed_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [W-1:0] m_level, m_rise, m_fall;
  logic         m_changed;
  logic [W-1:0] rawq [$];
  bit           hist [W][$];

  task automatic model_reset();
    m_level   = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_changed = 1'b0;
    rawq.delete();
    for (int i = 0; i < S; i++) rawq.push_back('0);
    for (int b = 0; b < W; b++) hist[b].delete();
  endtask

  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] s;
    bit           all_diff;
    s = rawq.pop_front();
    rawq.push_back(r);
    m_rise = '0;
    m_fall = '0;
    for (int b = 0; b < W; b++) begin
      hist[b].push_back(s[b]);
      if (hist[b].size() > D) void'(hist[b].pop_front());
      all_diff = (hist[b].size() == D);
      foreach (hist[b][j]) if (hist[b][j] == m_level[b]) all_diff = 0;
      if (all_diff) begin
        if (s[b]) m_rise[b] = 1'b1;
        else      m_fall[b] = 1'b1;
        m_level[b] = s[b];
      end
    end
    m_changed = |{m_rise, m_fall};
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("level",   32'(level_o),   32'(m_level));
    chk("rise",    32'(rise_o),    32'(m_rise));
    chk("fall",    32'(fall_o),    32'(m_fall));
    chk("changed", 32'(changed_o), 32'(m_changed));
  endtask

  // One clock: input already stable since the last check, sample the edge,
  // advance the model, then check 1 time unit later.
  task automatic cycle(input logic [W-1:0] r);
    raw_i = r;
    @(posedge clk);
    if (rstn) model_edge(r);
    #1;
    compare();
  endtask

  task automatic assert_reset();
    rstn = 1'b0;
    model_reset();
    #1;
    compare();
  endtask

  int pulses;
  logic [W-1:0] rv;
  logic [8:0] bounce;

  initial begin
    // 1. Reset with all inputs high
    raw_i = 4'hF;
    rstn  = 1'b0;
    model_reset();
    #1;
    compare();
    chk("reset_level", 32'(level_o), 32'h0);
    cycle(4'hF);
    cycle(4'hF);
    chk("reset_hold_rise", 32'(rise_o), 32'h0);
    #2 rstn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle(4'hF);
      if (i == 5) chk("t1_level_e5", 32'(level_o), 32'h0);
      if (i == 6) begin
        chk("t1_level_e6", 32'(level_o), 32'hF);
        chk("t1_rise_e6",  32'(rise_o),  32'hF);
        chk("t1_chg_e6",   32'(changed_o), 32'h1);
      end
      if (i == 7) chk("t1_rise_e7", 32'(rise_o), 32'h0);
    end

    // 2. Clean step on bit 0 (first bring everything low)
    repeat (8) cycle(4'h0);
    for (int i = 1; i <= 7; i++) begin
      cycle(4'h1);
      if (i == 5) chk("t2_level_e5", 32'(level_o), 32'h0);
      if (i == 6) begin
        chk("t2_rise_e6", 32'(rise_o), 32'h1);
        chk("t2_lvl_e6",  32'(level_o), 32'h1);
      end
      if (i == 7) chk("t2_rise_e7", 32'(rise_o), 32'h0);
    end
    for (int i = 1; i <= 7; i++) begin
      cycle(4'h0);
      if (i == 6) chk("t2_fall_e6", 32'(fall_o), 32'h1);
    end

    // 3. Glitch of 3 cycles on bit 1 is rejected, 5 cycles accepted
    pulses = 0;
    repeat (3) begin cycle(4'h2); pulses += int'(changed_o); end
    repeat (8) begin cycle(4'h0); pulses += int'(changed_o); end
    chk("t3_glitch_pulses", 32'(pulses), 32'h0);
    chk("t3_glitch_level",  32'(level_o), 32'h0);
    repeat (5) cycle(4'h2);
    repeat (3) cycle(4'h0);
    chk("t3_accept_level", 32'(level_o), 32'h2);

    // 4. Bounce 1,0,1,1,0,1,1,1,1 on bit 2 (bit 1 now low again later)
    repeat (8) cycle(4'h0);
    bounce = 9'b111101101;  // applied LSB first
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      cycle({1'b0, bounce[i], 2'b00});
      pulses += int'(rise_o[2]);
    end
    repeat (8) begin cycle(4'h4); pulses += int'(rise_o[2]); end
    chk("t4_bounce_pulses", 32'(pulses), 32'h1);

    // 5. Simultaneous rise on bit 0 and fall on bit 3
    repeat (8) cycle(4'h8);
    for (int i = 1; i <= 7; i++) begin
      cycle(4'h1);
      if (i == 6) begin
        chk("t5_rise", 32'(rise_o),    32'h1);
        chk("t5_fall", 32'(fall_o),    32'h8);
        chk("t5_chg",  32'(changed_o), 32'h1);
      end
      if (i == 7) chk("t5_chg_e7", 32'(changed_o), 32'h0);
    end

    // 6. Reset two cycles into a pending count on bit 1
    repeat (4) cycle(4'h3);
    assert_reset();
    chk("t6_reset_level", 32'(level_o), 32'h0);
    repeat (2) cycle(4'h3);
    #2 rstn = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      cycle(4'h3);
      if (i == 5) chk("t6_level_e5", 32'(level_o), 32'h0);
      if (i == 6) chk("t6_rise_e6",  32'(rise_o),  32'h3);
    end

    // Random: per-bit flips with low probability so both long and short runs occur
    rv = '0;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < W; b++)
        if ($urandom_range(5) == 0) rv[b] = ~rv[b];
      if (i == 300) begin
        assert_reset();
        cycle(rv);
        #2 rstn = 1'b1;
      end
      cycle(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
